// File: rtl/wave_pkg.sv
// Shared types and helpers for the two-bank waveform capture controller.
package wave_pkg;

    localparam int ADDR_W_DEFAULT = 9;

    typedef enum logic [1:0] {
        ARM    = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2,
        WAIT   = 2'd3
    } wave_state_t;

    // Keep the top byte of a signed sample and flip its sign bit so the RAM holds offset-binary.
    function automatic logic [7:0] to_offset_binary(input logic [15:0] smp);
        return {~smp[15], smp[14:8]};
    endfunction

endpackage

// File: rtl/wave_trig_detect.sv
// Level-crossing qualifier: pre_ok arms the trigger, cross_ok fires it, for either slope.
module wave_trig_detect (
    input  logic signed [7:0] s,
    input  logic signed [7:0] trig_level,
    input  logic              trig_slope,
    output logic              pre_ok,
    output logic              cross_ok
);

    always_comb begin
        if (trig_slope) begin
            pre_ok   = (s > trig_level);
            cross_ok = (s <= trig_level);
        end else begin
            pre_ok   = (s < trig_level);
            cross_ok = (s >= trig_level);
        end
    end

endmodule

// File: rtl/wave_trigger_ctrl.sv
// Triggered capture of one bank of samples into the back bank of a two-bank RAM, then a
// display-synchronised bank swap. Define WAVE_TRIG_AUTO_EN to enable forced capture on timeout.
module wave_trigger_ctrl
    import wave_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEFAULT,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_sample_ready,
    input  logic [15:0]       new_sample_in,
    input  logic [7:0]        trig_level,
    input  logic              trig_slope,
    input  logic              wave_display_idle,
    output logic [ADDR_W-1:0] write_address,
    output logic              write_enable,
    output logic [7:0]        write_sample,
    output logic              read_index,
    output logic              armed,
    output logic              auto_triggered
);

    localparam int OFF_W = ADDR_W - 1;
    localparam logic [OFF_W-1:0] LAST_OFF = '1;

    wave_state_t       state_q, state_d;
    logic [OFF_W-1:0]  offset_q, offset_d;
    logic              read_index_q, read_index_d;
    logic              write_enable_q, write_enable_d;
    logic [ADDR_W-1:0] write_address_q, write_address_d;
    logic [7:0]        write_sample_q, write_sample_d;
    logic              armed_q, armed_d;

    logic pre_ok, cross_ok, timeout, start_capture;

    wave_trig_detect u_detect (
        .s          (new_sample_in[15:8]),
        .trig_level (trig_level),
        .trig_slope (trig_slope),
        .pre_ok     (pre_ok),
        .cross_ok   (cross_ok)
    );

    always_comb begin
        state_d         = state_q;
        offset_d        = offset_q;
        read_index_d    = read_index_q;
        write_enable_d  = 1'b0;
        write_address_d = write_address_q;
        write_sample_d  = write_sample_q;
        start_capture   = 1'b0;

        case (state_q)
            ARM: begin
                if (new_sample_ready) begin
                    if (timeout)
                        start_capture = 1'b1;
                    else if (pre_ok)
                        state_d = ARMED;
                end
            end
            ARMED: begin
                if (new_sample_ready && (cross_ok || timeout))
                    start_capture = 1'b1;
            end
            ACTIVE: begin
                if (new_sample_ready) begin
                    write_enable_d  = 1'b1;
                    write_address_d = {~read_index_q, offset_q};
                    write_sample_d  = to_offset_binary(new_sample_in);
                    offset_d        = offset_q + OFF_W'(1);
                    if (offset_q == LAST_OFF)
                        state_d = WAIT;
                end
            end
            WAIT: begin
                // Samples are dropped here; only the display handshake matters.
                if (wave_display_idle) begin
                    read_index_d = ~read_index_q;
                    state_d      = ARM;
                end
            end
            default: state_d = ARM;
        endcase

        if (start_capture) begin
            write_enable_d  = 1'b1;
            write_address_d = {~read_index_q, {OFF_W{1'b0}}};
            write_sample_d  = to_offset_binary(new_sample_in);
            offset_d        = OFF_W'(1);
            state_d         = ACTIVE;
        end

        armed_d = (state_d == ARMED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ARM;
            offset_q        <= '0;
            read_index_q    <= 1'b0;
            write_enable_q  <= 1'b0;
            write_address_q <= '0;
            write_sample_q  <= '0;
            armed_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            offset_q        <= offset_d;
            read_index_q    <= read_index_d;
            write_enable_q  <= write_enable_d;
            write_address_q <= write_address_d;
            write_sample_q  <= write_sample_d;
            armed_q         <= armed_d;
        end
    end

`ifdef WAVE_TRIG_AUTO_EN
    localparam int CNT_W = $clog2(AUTO_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             auto_pend_q, auto_pend_d;
    logic             auto_triggered_q, auto_triggered_d;

    // Timeout fires on the sample that would bring the count to AUTO_TIMEOUT.
    assign timeout = (cnt_q == CNT_W'(AUTO_TIMEOUT - 1));

    always_comb begin
        cnt_d            = cnt_q;
        auto_pend_d      = auto_pend_q;
        auto_triggered_d = auto_triggered_q;
        if (state_q == WAIT && state_d == ARM)
            cnt_d = '0;
        else if ((state_q == ARM || state_q == ARMED) && new_sample_ready)
            cnt_d = cnt_q + CNT_W'(1);
        // A genuine crossing in ARMED wins over a coincident timeout.
        if (start_capture)
            auto_pend_d = !(state_q == ARMED && cross_ok);
        if (state_q == ACTIVE && state_d == WAIT)
            auto_triggered_d = auto_pend_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q            <= '0;
            auto_pend_q      <= 1'b0;
            auto_triggered_q <= 1'b0;
        end else begin
            cnt_q            <= cnt_d;
            auto_pend_q      <= auto_pend_d;
            auto_triggered_q <= auto_triggered_d;
        end
    end

    assign auto_triggered = auto_triggered_q;
`else
    logic unused_auto_timeout;
    assign unused_auto_timeout = (AUTO_TIMEOUT != 0);
    assign timeout             = 1'b0;
    assign auto_triggered      = 1'b0;
`endif

    assign write_address = write_address_q;
    assign write_enable  = write_enable_q;
    assign write_sample  = write_sample_q;
    assign read_index    = read_index_q;
    assign armed         = armed_q;

endmodule

// File: tb/tb_wave_trigger_ctrl.sv
// Randomised and directed bench for wave_trigger_ctrl with a behavioural capture model.
module tb_wave_trigger_ctrl;

    localparam int ADDR_W  = 9;
    localparam int BANK    = 1 << (ADDR_W - 1);
    localparam int TIMEOUT = 8;
`ifdef WAVE_TRIG_AUTO_EN
    localparam bit AUTO_ON = 1'b1;
`else
    localparam bit AUTO_ON = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              new_sample_ready;
    logic [15:0]       new_sample_in;
    logic [7:0]        trig_level;
    logic              trig_slope;
    logic              wave_display_idle;
    logic [ADDR_W-1:0] write_address;
    logic              write_enable;
    logic [7:0]        write_sample;
    logic              read_index;
    logic              armed;
    logic              auto_triggered;

    int checks = 0;
    int errors = 0;

    wave_trigger_ctrl #(.ADDR_W(ADDR_W), .AUTO_TIMEOUT(TIMEOUT)) dut (
        .clk               (clk),
        .reset             (reset),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .trig_level        (trig_level),
        .trig_slope        (trig_slope),
        .wave_display_idle (wave_display_idle),
        .write_address     (write_address),
        .write_enable      (write_enable),
        .write_sample      (write_sample),
        .read_index        (read_index),
        .armed             (armed),
        .auto_triggered    (auto_triggered)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: capture position (-1 = not capturing), armed/wait flags, displayed bank.
    int   cap_off = -1;
    bit   m_armed, m_wait, m_ri, m_auto, m_pend;
    int   m_cnt;
    bit   e_we;
    int   e_addr, e_data;

    always @(posedge clk) begin
        logic        r, rdy, idl, slp;
        logic [15:0] smp;
        logic [7:0]  lvl_u;
        int          s, lvl;
        bit          fires, pre;
        r = reset; rdy = new_sample_ready; idl = wave_display_idle;
        slp = trig_slope; smp = new_sample_in; lvl_u = trig_level;
        s   = $signed(smp[15:8]);
        lvl = $signed(lvl_u);
        e_we = 1'b0;
        if (r) begin
            cap_off = -1; m_armed = 0; m_wait = 0; m_ri = 0; m_auto = 0; m_pend = 0;
            m_cnt = 0; e_addr = 0; e_data = 0;
        end else if (m_wait) begin
            if (idl) begin
                m_ri = !m_ri; m_wait = 0; m_cnt = 0;
            end
        end else if (rdy) begin
            fires = slp ? (s <= lvl) : (s >= lvl);
            pre   = slp ? (s > lvl) : (s < lvl);
            if (cap_off < 0) begin
                m_cnt++;
                if (m_armed && fires) begin
                    cap_off = 0; m_pend = 0;
                end else if (AUTO_ON && m_cnt == TIMEOUT) begin
                    cap_off = 0; m_pend = 1;
                end else if (!m_armed && pre) begin
                    m_armed = 1;
                end
                if (cap_off == 0) m_armed = 0;
            end
            if (cap_off >= 0) begin
                e_we   = 1'b1;
                e_addr = (m_ri ? 0 : BANK) + cap_off;
                e_data = (s + 128) % 256;
                cap_off++;
                if (cap_off == BANK) begin
                    cap_off = -1; m_wait = 1; m_auto = m_pend;
                end
            end
        end
        #1;
        chk("cmp_write_enable", 16'(write_enable), 16'(e_we));
        if (e_we) begin
            chk("cmp_write_address", 16'(write_address), 16'(e_addr));
            chk("cmp_write_sample", 16'(write_sample), 16'(e_data));
        end
        chk("cmp_read_index", 16'(read_index), 16'(m_ri));
        chk("cmp_armed", 16'(armed), 16'(m_armed));
        chk("cmp_auto_triggered", 16'(auto_triggered), 16'(m_auto));
    end

    // Called at a negedge: presents one strobe and returns at the next negedge.
    task automatic strobe(input logic [15:0] v);
        new_sample_ready = 1'b1;
        new_sample_in    = v;
        @(negedge clk);
        new_sample_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; new_sample_ready = 1'b0; new_sample_in = '0;
        trig_level = '0; trig_slope = 1'b0; wave_display_idle = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_we", 16'(write_enable), 16'h0);
        chk("reset_addr", 16'(write_address), 16'h0);
        chk("reset_ri", 16'(read_index), 16'h0);
        chk("reset_armed", 16'(armed), 16'h0);
        reset = 1'b0;

        // Rising trigger followed by back-to-back strobes through a full bank.
        strobe(16'hF000);
        chk("rise_armed", 16'(armed), 16'h1);
        strobe(16'hFF00);
        chk("rise_no_write", 16'(write_enable), 16'h0);
        strobe(16'h0100);
        chk("rise_we", 16'(write_enable), 16'h1);
        chk("rise_addr", 16'(write_address), 16'h100);
        chk("rise_data", 16'(write_sample), 16'h81);
        n = 1;
        for (int i = 1; i < BANK; i++) begin
            strobe({i[7:0], 8'h00});
            n += int'(write_enable);
        end
        chk("rise_write_count", 16'(n), 16'(BANK));
        chk("rise_last_addr", 16'(write_address), 16'h1FF);

        // Display busy: strobes in WAIT are dropped and no swap occurs.
        n = 0;
        repeat (50) begin
            strobe(16'($urandom));
            n += int'(write_enable);
        end
        chk("wait_writes", 16'(n), 16'h0);
        chk("wait_ri", 16'(read_index), 16'h0);
        wave_display_idle = 1'b1;
        @(negedge clk);
        chk("swap_ri", 16'(read_index), 16'h1);
        wave_display_idle = 1'b0;

        // Falling trigger lands in bank 0.
        trig_level = 8'h10; trig_slope = 1'b1;
        strobe(16'h2000);
        chk("fall_armed", 16'(armed), 16'h1);
        strobe(16'h0F00);
        chk("fall_we", 16'(write_enable), 16'h1);
        chk("fall_addr", 16'(write_address), 16'h000);
        chk("fall_data", 16'(write_sample), 16'h8F);

        // Reset while offset 100 is next: partial bank discarded, no swap.
        repeat (99) strobe(16'($urandom));
        #1 reset = 1'b1;
        #1;
        chk("midreset_we", 16'(write_enable), 16'h0);
        chk("midreset_addr", 16'(write_address), 16'h0);
        chk("midreset_data", 16'(write_sample), 16'h0);
        chk("midreset_ri", 16'(read_index), 16'h0);
        chk("midreset_armed", 16'(armed), 16'h0);
        @(negedge clk);
        reset = 1'b0;
        trig_level = 8'h00; trig_slope = 1'b0;
        strobe(16'hF000);
        strobe(16'h0100);
        chk("recap_addr", 16'(write_address), 16'h100);
        chk("recap_data", 16'(write_sample), 16'h81);
        repeat (BANK - 1) strobe(16'($urandom));
        chk("recap_auto_flag", 16'(auto_triggered), 16'h0);

        // Flat input below threshold: only the timeout can capture.
        pulse_reset();
        trig_level = 8'h40; trig_slope = 1'b0;
        n = 0;
        repeat (TIMEOUT) begin
            strobe(16'h0000);
            n += int'(write_enable);
        end
`ifdef WAVE_TRIG_AUTO_EN
        chk("auto_writes", 16'(n), 16'h1);
        chk("auto_addr", 16'(write_address), 16'h100);
        chk("auto_data", 16'(write_sample), 16'h80);
        repeat (BANK - 1) strobe(16'h0000);
        chk("auto_flag", 16'(auto_triggered), 16'h1);
`else
        chk("flat_no_writes", 16'(n), 16'h0);
        repeat (20) strobe(16'h0000);
        chk("flat_still_no_write", 16'(write_enable), 16'h0);
`endif

        // Randomised traffic checked by the model on every cycle.
        pulse_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 49) == 0) trig_level = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 49) == 0) trig_slope = 1'($urandom_range(0, 1));
            wave_display_idle = ($urandom_range(0, 3) == 0);
            new_sample_ready  = ($urandom_range(0, 9) < 7);
            new_sample_in     = 16'($urandom);
            @(negedge clk);
        end
        new_sample_ready = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_trigger_ctrl.md
# wave_trigger_ctrl

- Sequences the two-bank waveform sample RAM feeding the wave display.
- Watches the incoming audio sample stream and detects a level crossing with selectable slope.
- On a trigger, writes one bank-worth of 8-bit samples into the back bank, then swaps banks via `read_index` only while the display reports idle.
- Sits between the codec sample stream and the 1-write/2-read sample RAM, replacing the fixed zero-crossing capture logic.

## Interface
- `ADDR_W`, 9: RAM address width; MSB is the bank select, giving 2^(ADDR_W-1) samples per bank.
- `AUTO_TIMEOUT`, 4096: samples without a trigger before a forced capture (used only with `WAVE_TRIG_AUTO_EN`).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `new_sample_ready` in 1: one-cycle strobe; `new_sample_in` valid this cycle.
- `new_sample_in` in 16: signed two's-complement audio sample.
- `trig_level` in 8: signed threshold, compared against `new_sample_in[15:8]`.
- `trig_slope` in 1: 0 = rising crossing, 1 = falling crossing.
- `wave_display_idle` in 1: display is outside the active waveform region; a bank swap is safe.
- `write_address` out ADDR_W: `{~read_index, offset}`.
- `write_enable` out 1: one-cycle RAM write strobe.
- `write_sample` out 8: unsigned offset-binary sample, `{~s[15], s[14:8]}`.
- `read_index` out 1: bank currently shown by the display.
- `armed` out 1: high in `ARMED`.
- `auto_triggered` out 1: the last completed bank was a forced capture.

## Operation
- **States:** `ARM`, `ARMED`, `ACTIVE`, `WAIT`. Reset state is `ARM`.
- **Sample handling:** states act only on cycles with `new_sample_ready`=1, except `WAIT`. `s = new_sample_in[15:8]`, signed.
- **ARM:** on a sample with `s < trig_level` (rising) or `s > trig_level` (falling), go to `ARMED`. This sample is not written.
- **ARMED:** on a sample with `s >= trig_level` (rising) or `s <= trig_level` (falling), this is the trigger sample.
  - Write it at offset 0.
  - Set offset to 1 and go to `ACTIVE`.
- **ACTIVE:** every sample is written at the current offset, then offset increments.
  - The write at offset 2^(ADDR_W-1)-1 moves the FSM to `WAIT`.
  - Offset wraps to 0.
- **WAIT:** all samples are dropped. On the first cycle with `wave_display_idle`=1, toggle `read_index` and go to `ARM`.
- **Write bank:** always `~read_index`. The displayed bank is never written.
- **Threshold timing:** `trig_level` and `trig_slope` are sampled live. A change during `ACTIVE` or `WAIT` affects only the next arm.
- **Idle outside WAIT:** `wave_display_idle` is ignored in every state except `WAIT`.
- **Reset mid-capture:** the partial bank is discarded, with no swap. Every output and all internal state is cleared.
- **Arithmetic:** signed 8-bit compare; the offset counter is ADDR_W-1 bits and wraps naturally. No saturation is needed.

## Timing
- Reset value of every output is 0: `write_address`, `write_enable`, `write_sample`, `read_index`, `armed`, `auto_triggered`.
- **Write latency:** a sample strobed at cycle t that is written produces `write_enable`=1 at t+1, with `write_address` and `write_sample` registered together. `write_enable` is low on all other cycles.
- **Back-to-back strobes** (every cycle) are fully supported: one write per cycle, no drops outside `WAIT`/`ARM`.
- **Last-sample hand-off:** the last write of a bank occurs at t+1; the state is `WAIT` from t+1.
  - If `wave_display_idle`=1 at t+1, `read_index` toggles at t+2.
  - The final write therefore always lands before the swap.
- **Swap latency:** `read_index` changes one cycle after idle is sampled in `WAIT`.
- **armed** reflects the registered state, so it rises one cycle after the arming sample.

## Configuration
- `WAVE_TRIG_AUTO_EN` defined:
  - A sample counter runs in `ARM`/`ARMED`, cleared on entering `ARM`.
  - The sample that would make the count reach `AUTO_TIMEOUT` is treated as a trigger from either state. It is written at offset 0, and the FSM goes to `ACTIVE`.
  - `auto_triggered` is set on entering `WAIT` after a forced capture and cleared on entering `WAIT` after a real trigger.
- `WAVE_TRIG_AUTO_EN` undefined:
  - No counter exists; a flat input never captures.
  - `auto_triggered` is tied to 0.

## Structure
- **Shared package `wave_pkg`:**
  - state enum (`ARM`, `ARMED`, `ACTIVE`, `WAIT`);
  - `to_offset_binary` function (16-bit signed to 8-bit unsigned);
  - default `ADDR_W`.
- **Sub-module `wave_trig_detect`:** combinational; inputs `s`, `trig_level`, `trig_slope`; outputs `pre_ok` and `cross_ok`. The FSM, counters, and output registers stay in the top block.

## Test plan
- **Reset/idle:**
  - Assert `reset` mid-`ACTIVE` at offset 100 → all outputs 0 next cycle.
  - Re-capture starts from `ARM` at offset 0 in bank 1.
- **Rising trigger:**
  - Setup: `trig_level`=0, slope 0; samples 0xF000, 0xFF00, 0x0100, ramp.
  - Required response:
    - `armed` rises after 0xF000;
    - 0x0100 is written to address 0x100 as 0x81;
    - 255 more writes follow at 0x101–0x1FF;
    - the FSM enters `WAIT`.
- **Falling trigger:**
  - Setup: `trig_level`=0x10, slope 1; samples 0x2000 then 0x0F00.
  - Required response: 0x0F00 is written at offset 0 as 0x8F.
- **Swap handshake:**
  - Hold `wave_display_idle`=0 for 50 cycles in `WAIT` with strobes every cycle → no writes, `read_index` stays 0.
  - Raise idle → `read_index`=1 one cycle later; the next capture writes addresses 0x000–0x0FF.
- **Auto trigger (macro on, `AUTO_TIMEOUT`=8):**
  - Feed a constant 0x0000 with `trig_level`=0x40.
  - Required response: the 8th sample is written at offset 0, and `auto_triggered`=1 at `WAIT`.
  - With the macro off, the same stimulus produces no writes.
- **Back-to-back strobes:**
  - Strobe every cycle through a full capture → exactly 256 consecutive `write_enable` cycles, each one cycle after its sample.
